// File: rtl/fpsqrt_pkg.sv
// Shared definitions for the square-root front end: format encodings, field
// widths, biases, canonical special patterns and the stage payload structs.
package fpsqrt_pkg;

  localparam logic [1:0] FMT_FP16 = 2'd0;
  localparam logic [1:0] FMT_FP32 = 2'd1;
  localparam logic [1:0] FMT_FP64 = 2'd2;

  localparam int EXP_BITS_FP16 = 5;
  localparam int EXP_BITS_FP32 = 8;
  localparam int EXP_BITS_FP64 = 11;
  localparam int FRAC_W_FP16   = 10;
  localparam int FRAC_W_FP32   = 23;
  localparam int FRAC_W_FP64   = 52;

  localparam logic [10:0] BIAS_FP16 = 11'd15;
  localparam logic [10:0] BIAS_FP32 = 11'd127;
  localparam logic [10:0] BIAS_FP64 = 11'd1023;

  localparam logic [63:0] QNAN_FP64 = 64'h7FF8000000000000;
  localparam logic [31:0] QNAN_FP32 = 32'h7FC00000;
  localparam logic [15:0] QNAN_FP16 = 16'h7E00;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef struct packed {
    logic [52:0] sig;
    logic [5:0]  lzc;
    logic        special;
    logic [63:0] special_res;
    logic [4:0]  fflags;
    logic [1:0]  fmt;
    logic [2:0]  rm;
  } s0_pl_t;

  typedef struct packed {
    logic [52:0] frac;
    logic        exp_odd;
    logic [10:0] res_exp;
    logic        special;
    logic [63:0] special_res;
    logic [4:0]  fflags;
    logic [1:0]  fmt;
    logic [2:0]  rm;
  } s1_pl_t;

  function automatic logic [10:0] fmt_bias(input logic [1:0] fmt);
    case (fmt)
      FMT_FP16: return BIAS_FP16;
      FMT_FP32: return BIAS_FP32;
      default:  return BIAS_FP64;
    endcase
  endfunction

  // Narrow results are NaN-boxed into the 64-bit result bus.
  function automatic logic [63:0] fmt_qnan(input logic [1:0] fmt);
    case (fmt)
      FMT_FP16: return {48'hFFFF_FFFF_FFFF, QNAN_FP16};
      FMT_FP32: return {32'hFFFF_FFFF, QNAN_FP32};
      default:  return QNAN_FP64;
    endcase
  endfunction

  function automatic logic [63:0] fmt_inf(input logic [1:0] fmt);
    case (fmt)
      FMT_FP16: return {48'hFFFF_FFFF_FFFF, 16'h7C00};
      FMT_FP32: return {32'hFFFF_FFFF, 32'h7F80_0000};
      default:  return 64'h7FF0_0000_0000_0000;
    endcase
  endfunction

  function automatic logic [63:0] fmt_zero(input logic [1:0] fmt, input logic sgn);
    case (fmt)
      FMT_FP16: return {48'hFFFF_FFFF_FFFF, sgn, 15'd0};
      FMT_FP32: return {32'hFFFF_FFFF, sgn, 31'd0};
      default:  return {sgn, 63'd0};
    endcase
  endfunction

endpackage

// File: rtl/fpsqrt_lzc.sv
// 53-bit leading-zero counter; an all-zero input reports 53.
module fpsqrt_lzc (
  input  logic [52:0] sig_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    cnt_o = 6'd53;
    for (int i = 0; i < 53; i++) begin
      if (sig_i[i]) cnt_o = 6'(52 - i);
    end
  end

endmodule

// File: rtl/fpsqrt_pre_norm.sv
// Square-root operand pre-normalizer: 2-stage elastic pipeline producing a
// left-aligned 1.f significand, halved exponent and special-case result.
// Define FPSQRT_PRE_NORM_SUBNORM_EN to normalize subnormals instead of
// flushing them to signed zero.
module fpsqrt_pre_norm
  import fpsqrt_pkg::*;
#(
  parameter int EXP_W = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  input  logic        flush_i,
  input  logic [1:0]  fp_format_i,
  input  logic [63:0] op_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [52:0] out_frac_o,
  output logic        out_exp_odd_o,
  output logic [10:0] out_res_exp_o,
  output logic        out_special_o,
  output logic [63:0] out_special_res_o,
  output logic [4:0]  out_fflags_o,
  output logic [1:0]  out_fp_format_o,
  output logic [2:0]  out_rm_o
);

  logic                    s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
  s0_pl_t                  s0_q, s0_d, s0_new;
  s1_pl_t                  s1_q, s1_d, s1_new;
  logic [EXP_W-1:0]        s0_ebase_q, s0_ebase_d, ebase_new;
  logic                    s0_adv, accept;

  logic                    in_sgn, exp_zero, exp_max, frac_nz, in_zero;
  logic [10:0]             in_exp, in_emax;
  logic [51:0]             in_frac;
  logic [52:0]             in_sig;
  logic [5:0]              in_lzc;
  logic signed [EXP_W-1:0] s1_e, s1_half;

  // Unpack into FP64-shaped fields: exponent right-aligned, fraction left-aligned.
  always_comb begin
    in_sgn  = op_i[FRAC_W_FP64+EXP_BITS_FP64];
    in_exp  = op_i[FRAC_W_FP64 +: EXP_BITS_FP64];
    in_frac = op_i[FRAC_W_FP64-1:0];
    in_emax = 11'((1 << EXP_BITS_FP64) - 1);
    case (fp_format_i)
      FMT_FP16: begin
        in_sgn  = op_i[FRAC_W_FP16+EXP_BITS_FP16];
        in_exp  = 11'(op_i[FRAC_W_FP16 +: EXP_BITS_FP16]);
        in_frac = {op_i[FRAC_W_FP16-1:0], {(52-FRAC_W_FP16){1'b0}}};
        in_emax = 11'((1 << EXP_BITS_FP16) - 1);
      end
      FMT_FP32: begin
        in_sgn  = op_i[FRAC_W_FP32+EXP_BITS_FP32];
        in_exp  = 11'(op_i[FRAC_W_FP32 +: EXP_BITS_FP32]);
        in_frac = {op_i[FRAC_W_FP32-1:0], {(52-FRAC_W_FP32){1'b0}}};
        in_emax = 11'((1 << EXP_BITS_FP32) - 1);
      end
      default: ;
    endcase
  end

  assign exp_zero = (in_exp == 11'd0);
  assign exp_max  = (in_exp == in_emax);
  assign frac_nz  = |in_frac;

`ifdef FPSQRT_PRE_NORM_SUBNORM_EN
  assign in_zero = exp_zero & ~frac_nz;
  assign in_sig  = {~exp_zero, in_frac};

  fpsqrt_lzc u_lzc (
    .sig_i (in_sig),
    .cnt_o (in_lzc)
  );
`else
  assign in_zero = exp_zero;
  assign in_sig  = {1'b1, in_frac};
  assign in_lzc  = '0;
`endif

  // Special priority: NaN, zero, negative, +inf; only the last case carries a significand.
  always_comb begin
    s0_new     = '0;
    s0_new.fmt = fp_format_i;
    s0_new.rm  = rm_i;
    ebase_new  = (exp_zero ? EXP_W'(1) : EXP_W'(in_exp)) - EXP_W'(fmt_bias(fp_format_i));
    if (exp_max && frac_nz) begin
      s0_new.special            = 1'b1;
      s0_new.special_res        = fmt_qnan(fp_format_i);
      s0_new.fflags[FFLAG_NV]   = ~in_frac[51];
    end else if (in_zero) begin
      s0_new.special            = 1'b1;
      s0_new.special_res        = fmt_zero(fp_format_i, in_sgn);
    end else if (in_sgn) begin
      s0_new.special            = 1'b1;
      s0_new.special_res        = fmt_qnan(fp_format_i);
      s0_new.fflags[FFLAG_NV]   = 1'b1;
    end else if (exp_max) begin
      s0_new.special            = 1'b1;
      s0_new.special_res        = fmt_inf(fp_format_i);
    end else begin
      s0_new.sig = in_sig;
      s0_new.lzc = in_lzc;
    end
  end

  always_comb begin
    s1_e    = $signed(s0_ebase_q - EXP_W'(s0_q.lzc));
    s1_half = s1_e >>> 1;
    s1_new             = '0;
    s1_new.special     = s0_q.special;
    s1_new.special_res = s0_q.special_res;
    s1_new.fflags      = s0_q.fflags;
    s1_new.fmt         = s0_q.fmt;
    s1_new.rm          = s0_q.rm;
    if (!s0_q.special) begin
      s1_new.frac    = s0_q.sig << s0_q.lzc;
      s1_new.exp_odd = s1_e[0];
      s1_new.res_exp = 11'(s1_half + $signed(EXP_W'(fmt_bias(s0_q.fmt))));
    end
  end

  always_comb begin
    s0_adv        = ~s1_valid_q | out_ready_i;
    start_ready_o = ~s0_valid_q | s0_adv;
    accept        = start_valid_i & start_ready_o;

    s0_valid_d = s0_valid_q;
    s0_d       = s0_q;
    s0_ebase_d = s0_ebase_q;
    if (start_ready_o) s0_valid_d = start_valid_i;
    if (accept) begin
      s0_d       = s0_new;
      s0_ebase_d = ebase_new;
    end

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s0_adv) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) s1_d = s1_new;
    end

    if (flush_i) begin
      s0_valid_d = 1'b0;
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s0_q       <= '0;
      s0_ebase_q <= '0;
      s1_q       <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
      s0_q       <= s0_d;
      s0_ebase_q <= s0_ebase_d;
      s1_q       <= s1_d;
    end
  end

  assign out_valid_o       = s1_valid_q;
  assign out_frac_o        = s1_q.frac;
  assign out_exp_odd_o     = s1_q.exp_odd;
  assign out_res_exp_o     = s1_q.res_exp;
  assign out_special_o     = s1_q.special;
  assign out_special_res_o = s1_q.special_res;
  assign out_fflags_o      = s1_q.fflags;
  assign out_fp_format_o   = s1_q.fmt;
  assign out_rm_o          = s1_q.rm;

endmodule

// File: tb/tb_fpsqrt_pre_norm.sv
// Self-checking bench for fpsqrt_pre_norm: directed cases, back-pressure,
// flush/reset and a randomized stream against a value-level reference model.
module tb_fpsqrt_pre_norm;

`ifdef FPSQRT_PRE_NORM_SUBNORM_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  typedef struct packed {
    logic [52:0] frac;
    logic        odd;
    logic [10:0] rexp;
    logic        special;
    logic [63:0] res;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic [2:0]  rm;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic [1:0]  fp_format_i = '0;
  logic [63:0] op_i = '0;
  logic [2:0]  rm_i = '0;
  logic        start_ready_o, out_valid_o, out_exp_odd_o, out_special_o;
  logic [52:0] out_frac_o;
  logic [10:0] out_res_exp_o;
  logic [63:0] out_special_res_o;
  logic [4:0]  out_fflags_o;
  logic [1:0]  out_fp_format_o;
  logic [2:0]  out_rm_o;

  int   checks = 0, failures = 0;
  exp_t q[$];

  fpsqrt_pre_norm dut (
    .clk(clk), .rst_n(rst_n), .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .flush_i(flush_i), .fp_format_i(fp_format_i), .op_i(op_i), .rm_i(rm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_frac_o(out_frac_o),
    .out_exp_odd_o(out_exp_odd_o), .out_res_exp_o(out_res_exp_o), .out_special_o(out_special_o),
    .out_special_res_o(out_special_res_o), .out_fflags_o(out_fflags_o),
    .out_fp_format_o(out_fp_format_o), .out_rm_o(out_rm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t x);
    chk({tag, "_frac"},    64'(out_frac_o),      64'(x.frac));
    chk({tag, "_odd"},     64'(out_exp_odd_o),   64'(x.odd));
    chk({tag, "_rexp"},    64'(out_res_exp_o),   64'(x.rexp));
    chk({tag, "_special"}, 64'(out_special_o),   64'(x.special));
    chk({tag, "_res"},     out_special_res_o,    x.res);
    chk({tag, "_fflags"},  64'(out_fflags_o),    64'(x.flags));
    chk({tag, "_fmt"},     64'(out_fp_format_o), 64'(x.fmt));
    chk({tag, "_rm"},      64'(out_rm_o),        64'(x.rm));
  endtask

  function automatic void fmt_info(input logic [1:0] fmt, output int ew, output int fw, output int bias);
    case (fmt)
      2'd0:    begin ew = 5;  fw = 10; bias = 15;   end
      2'd1:    begin ew = 8;  fw = 23; bias = 127;  end
      default: begin ew = 11; fw = 52; bias = 1023; end
    endcase
  endfunction

  // Reference: decode the value arithmetically and apply the sqrt pre-normalization rules.
  function automatic exp_t model(input logic [1:0] fmt, input logic [63:0] op, input logic [2:0] rm);
    exp_t r;
    int ew, fw, bias, e, p;
    logic [63:0] E, F, emax, box, qn;
    logic sgn;
    fmt_info(fmt, ew, fw, bias);
    box = (fmt == 2'd0) ? 64'hFFFF_FFFF_FFFF_0000 : (fmt == 2'd1) ? 64'hFFFF_FFFF_0000_0000 : 64'd0;
    qn  = (fmt == 2'd0) ? 64'h7E00 : (fmt == 2'd1) ? 64'h7FC0_0000 : 64'h7FF8_0000_0000_0000;
    r = '0; r.fmt = fmt; r.rm = rm;
    emax = (64'd1 << ew) - 1;
    sgn  = op[ew+fw];
    E    = (op >> fw) & emax;
    F    = op & ((64'd1 << fw) - 1);
    if (E == emax && F != 0) begin
      r.special = 1'b1; r.res = box | qn; r.flags = F[fw-1] ? 5'b00000 : 5'b10000;
    end else if (E == 0 && (F == 0 || !SUB)) begin
      r.special = 1'b1; r.res = box | (sgn ? (64'd1 << (ew + fw)) : 64'd0);
    end else if (sgn) begin
      r.special = 1'b1; r.res = box | qn; r.flags = 5'b10000;
    end else if (E == emax) begin
      r.special = 1'b1; r.res = box | (emax << fw);
    end else begin
      if (E != 0) begin
        e = int'(E) - bias;
        r.frac = 53'(((64'd1 << fw) | F) << (52 - fw));
      end else begin
        p = 0;
        for (int i = 0; i < fw; i++) if (F[i]) p = i;
        e = 1 - bias - (fw - p);
        r.frac = 53'(F << (52 - p));
      end
      r.odd  = e[0];
      r.rexp = 11'((e >= 0 ? e / 2 : -((1 - e) / 2)) + bias);
    end
    return r;
  endfunction

  function automatic logic [63:0] gen_op(input logic [1:0] fmt);
    int ew, fw, bias;
    logic [63:0] E, F, emax, mask, v;
    logic s;
    fmt_info(fmt, ew, fw, bias);
    emax = (64'd1 << ew) - 1;
    F = {$urandom, $urandom} & ((64'd1 << fw) - 1);
    s = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 7))
      0: begin E = 0; F = 0; end
      1: begin E = 0; if (F == 0) F = 1; end
      2: begin E = emax; F = 0; end
      3: begin E = emax; if (F == 0) F = 1; end
      default: E = 64'($urandom_range(1, int'(emax) - 1));
    endcase
    mask = (fmt == 2'd2) ? '1 : ((64'd1 << (ew + fw + 1)) - 1);
    v = (64'(s) << (ew + fw)) | (E << fw) | F;
    return ({$urandom, $urandom} & ~mask) | (v & mask);
  endfunction

  function automatic exp_t mk(input logic [52:0] frac, input logic odd, input logic [10:0] rexp,
                              input logic sp, input logic [63:0] res, input logic [4:0] fl,
                              input logic [1:0] fmt, input logic [2:0] rm);
    exp_t r;
    r.frac = frac; r.odd = odd; r.rexp = rexp; r.special = sp;
    r.res = res; r.flags = fl; r.fmt = fmt; r.rm = rm;
    return r;
  endfunction

  // One op through an idle pipeline with directed expectations and a 2-cycle latency check.
  task automatic single(input string tag, input logic [1:0] fmt, input logic [63:0] op, input exp_t x);
    @(negedge clk);
    start_valid_i = 1'b1; fp_format_i = fmt; op_i = op; rm_i = x.rm; out_ready_i = 1'b1; flush_i = 1'b0;
    #1 chk({tag, "_ready"}, 64'(start_ready_o), 64'd1);
    @(negedge clk);
    start_valid_i = 1'b0;
    #1 chk({tag, "_lat1_valid"}, 64'(out_valid_o), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2_valid"}, 64'(out_valid_o), 64'd1);
    cmp_out(tag, x);
  endtask

  // One cycle of streaming traffic with scoreboard-driven output checks.
  task automatic step(input logic sv, input logic [1:0] fmt, input logic [63:0] op,
                      input logic ordy, input logic fl);
    @(negedge clk);
    start_valid_i = sv; fp_format_i = fmt; op_i = op; rm_i = 3'($urandom_range(0, 4));
    out_ready_i = ordy; flush_i = fl;
    #1;
    if (q.size() == 0) chk("idle_valid", 64'(out_valid_o), 64'd0);
    else if (out_valid_o) begin
      cmp_out("stream", q[0]);
      if (out_ready_i) void'(q.pop_front());
    end
    if (sv && start_ready_o) q.push_back(model(fmt, op, rm_i));
    if (fl) q.delete();
  endtask

  initial begin
    logic [63:0] ops[4];

    // Reset with junk on the inputs.
    start_valid_i = 1'b1; op_i = 64'h4010_0000_0000_0000; fp_format_i = 2'd2; rm_i = 3'd4; out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ready", 64'(start_ready_o), 64'd1);
    cmp_out("rst", '0);
    rst_n = 1'b1; start_valid_i = 1'b0;

    // Directed values.
    single("fp32_4p0", 2'd1, 64'h0000_0000_4080_0000,
           mk(53'h10000000000000, 1'b0, 11'd128, 1'b0, 64'd0, 5'd0, 2'd1, 3'd3));
    single("fp32_2p0", 2'd1, 64'h0000_0000_4000_0000,
           mk(53'h10000000000000, 1'b1, 11'd127, 1'b0, 64'd0, 5'd0, 2'd1, 3'd0));
`ifdef FPSQRT_PRE_NORM_SUBNORM_EN
    single("fp64_min_sub", 2'd2, 64'h1, mk(53'h10000000000000, 1'b0, 11'd486, 1'b0, 64'd0, 5'd0, 2'd2, 3'd1));
`else
    single("fp64_min_sub", 2'd2, 64'h1, mk(53'd0, 1'b0, 11'd0, 1'b1, 64'd0, 5'd0, 2'd2, 3'd1));
`endif
    single("fp64_neg1", 2'd2, 64'hBFF0_0000_0000_0000,
           mk(53'd0, 1'b0, 11'd0, 1'b1, 64'h7FF8_0000_0000_0000, 5'b10000, 2'd2, 3'd2));
    single("fp16_snan", 2'd0, 64'h0000_0000_0000_7D00,
           mk(53'd0, 1'b0, 11'd0, 1'b1, 64'hFFFF_FFFF_FFFF_7E00, 5'b10000, 2'd0, 3'd4));
    single("fp16_pinf", 2'd0, 64'h0000_0000_0000_7C00,
           mk(53'd0, 1'b0, 11'd0, 1'b1, 64'hFFFF_FFFF_FFFF_7C00, 5'd0, 2'd0, 3'd0));
    single("fp32_nzero", 2'd1, 64'h0000_0000_8000_0000,
           mk(53'd0, 1'b0, 11'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 5'd0, 2'd1, 3'd0));
    step(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);

    // Back-pressure: two accepts then stall, stable outputs, in-order drain at 1/cycle.
    for (int i = 0; i < 4; i++) ops[i] = gen_op(2'd2);
    step(1'b1, 2'd2, ops[0], 1'b0, 1'b0); chk("bp_ready0", 64'(start_ready_o), 64'd1);
    step(1'b1, 2'd2, ops[1], 1'b0, 1'b0); chk("bp_ready1", 64'(start_ready_o), 64'd1);
    step(1'b1, 2'd2, ops[2], 1'b0, 1'b0); chk("bp_ready_full", 64'(start_ready_o), 64'd0);
    step(1'b1, 2'd2, ops[2], 1'b0, 1'b0); chk("bp_hold_valid", 64'(out_valid_o), 64'd1);
    step(1'b1, 2'd2, ops[2], 1'b0, 1'b0); chk("bp_hold_ready", 64'(start_ready_o), 64'd0);
    step(1'b1, 2'd2, ops[2], 1'b1, 1'b0); chk("bp_full_accept", 64'(start_ready_o), 64'd1);
    step(1'b1, 2'd2, ops[3], 1'b1, 1'b0); chk("bp_drain1", 64'(out_valid_o), 64'd1);
    step(1'b0, 2'd2, 64'd0, 1'b1, 1'b0);  chk("bp_drain2", 64'(out_valid_o), 64'd1);
    step(1'b0, 2'd2, 64'd0, 1'b1, 1'b0);  chk("bp_drain3", 64'(out_valid_o), 64'd1);
    chk("bp_all_out", 64'(q.size()), 64'd0);

    // Flush with both stages full and a third op presented.
    step(1'b1, 2'd1, gen_op(2'd1), 1'b0, 1'b0);
    step(1'b1, 2'd1, gen_op(2'd1), 1'b0, 1'b0);
    step(1'b1, 2'd1, gen_op(2'd1), 1'b0, 1'b1);
    step(1'b0, 2'd1, 64'd0, 1'b1, 1'b0); chk("flush_ready", 64'(start_ready_o), 64'd1);
    repeat (3) step(1'b0, 2'd1, 64'd0, 1'b1, 1'b0);

    // Flush coinciding with an accepted op drops that op too.
    step(1'b1, 2'd0, gen_op(2'd0), 1'b1, 1'b1);
    repeat (3) step(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);

    // Reset mid-operation discards in-flight ops.
    step(1'b1, 2'd2, gen_op(2'd2), 1'b0, 1'b0);
    step(1'b1, 2'd2, gen_op(2'd2), 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; start_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; q.delete();
    #1 chk("midrst_ready", 64'(start_ready_o), 64'd1);
    repeat (3) step(1'b0, 2'd2, 64'd0, 1'b1, 1'b0);

    // Randomized stream with random back-pressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] f;
      f = 2'($urandom_range(0, 2));
      step($urandom_range(0, 9) < 7, f, gen_op(f), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
